pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the RV32I 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Drives per-register stall and flush (bubble) controls.
- Generates EX-stage operand-forwarding selects.
- Runs a small FSM that freezes the pipeline during multi-cycle data-memory accesses, with a timeout halt.
- Keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before halt (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs1, id_rs2  in  5 each  source registers of instruction in ID
id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  5 each  ID/EX reg_src1/reg_src2
ex_rd  in  5  ID/EX destination
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  branch taken / jump resolved in EX
mem_rd  in  5  EX/MEM rd
mem_reg_write  in  1  EX/MEM reg_write
wb_rd  in  5  MEM/WB rd
wb_reg_write  in  1  MEM/WB reg_write
dmem_req  in  1  MEM stage has an active load/store
dmem_ready  in  1  data memory completes access this cycle
pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold register contents
ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble (all controls 0)
fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM alu, 10 MEM/WB result
timeout_err  out  1  sticky halt indicator
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1
flush_events  out  CNT_W  saturating count of redirect flushes

Behaviour:
FSM states and transitions:
- RUN -> MEM_WAIT when dmem_req && !dmem_ready.
- MEM_WAIT -> RUN when dmem_ready.
- MEM_WAIT -> HALT when wait_cnt == MEM_TIMEOUT-1 && !dmem_ready.
- HALT is terminal until reset.

wait_cnt:
- Clears on entry to MEM_WAIT, increments each MEM_WAIT cycle.
- Width is clog2(MEM_TIMEOUT)+1.

Control outputs (combinational from state and inputs, fixed priority):
1. HALT:
   - All four stalls = 1, memwb_flush = 1, timeout_err = 1.
   - dmem_ready is ignored.
2. Memory freeze (state MEM_WAIT, or RUN with dmem_req && !dmem_ready):
   - pc/ifid/idex/exmem stalls = 1, memwb_flush = 1.
   - ifid_flush = idex_flush = 0.
   - Redirect is ignored; it is not latched. ID/EX is frozen, so ex_redirect re-presents itself after the freeze.
   - The cycle dmem_ready=1 is a normal cycle (no freeze).
3. Redirect (ex_redirect=1):
   - ifid_flush = idex_flush = 1, no stalls.
   - Redirect overrides load-use.
4. Load-use: ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
   - pc_stall = ifid_stall = 1, idex_flush = 1.
   - Lasts exactly one cycle per hazard.
5. Otherwise all controls = 0.

Forwarding (independent of state):
- fwd_a = 01 if mem_reg_write && mem_rd != 0 && mem_rd == ex_rs1.
- Else fwd_a = 10 if wb_reg_write && wb_rd != 0 && wb_rd == ex_rs1.
- Else fwd_a = 00.
- fwd_b is identical using ex_rs2.
- EX/MEM has priority over MEM/WB.

Counters:
- stall_cycles increments when pc_stall=1; saturates at all-ones.
- flush_events increments on each cycle where rule 3 applies; saturates at all-ones.

Reset (asynchronous, active-high):
- state = RUN, wait_cnt = 0, counters = 0, timeout_err = 0.
- While reset is high: all stalls = 0, ifid_flush = idex_flush = memwb_flush = 1, fwd = 00.
- Reset asserted mid MEM_WAIT or HALT returns to RUN immediately.

Decomposition:
- Shared package pipe_pkg: state enum (RUN, MEM_WAIT, HALT), fwd select constants FWD_REG/FWD_EXMEM/FWD_MEMWB.
- Sub-module fwd_unit: purely combinational forwarding; instantiated once, producing both fwd_a and fwd_b.

Test Plan:
1. Forwarding:
   - ex_rs1=5, mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1 -> fwd_a=01.
   - Same with mem_reg_write=0 -> fwd_a=10.
   - Same with rd=0 -> fwd_a=00.
2. Load-use:
   - ex_mem_read=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> one cycle pc_stall=ifid_stall=idex_flush=1.
   - Same hazard with id_use_rs2=0 -> no stall.
   - stall_cycles increments by 1 for the stalled cycle.
3. Redirect vs load-use:
   - ex_redirect=1 together with a load-use hazard -> ifid_flush=idex_flush=1, pc_stall=0, flush_events+1.
4. Memory wait:
   - dmem_req=1, dmem_ready low for 3 cycles then high -> freeze on 3 cycles (memwb_flush=1), state back to RUN.
   - Concurrent ex_redirect is ignored during the freeze and honoured on the first unfrozen cycle.
5. Timeout:
   - MEM_TIMEOUT=4, dmem_ready held 0 -> HALT after 4 wait cycles, timeout_err=1 and stays 1 after dmem_ready=1.
   - Async reset pulse -> RUN, timeout_err=0, counters 0.
6. Saturation:
   - CNT_W=4, force 20 stall cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the RV32I pipeline hazard controller
// Sequencer states, forwarding select codes and the forwarding pick helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Youngest producer wins: EX/MEM result is newer than MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs,
                                          input logic [4:0] mem_rd,
                                          input logic       mem_reg_write,
                                          input logic [4:0] wb_rd,
                                          input logic       wb_reg_write);
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs)
      return FWD_EXMEM;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// rtl/pipe_hazard_ctrl_fwd_unit.sv - combinational EX operand forwarding selects
// Produces both ALU operand selects from the EX/MEM and MEM/WB destinations.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_pick(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_pick(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding control for the 5-stage pipeline
// Freezes the pipe on slow data-memory accesses and halts on a stuck access.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            halted;
  logic            freeze;
  logic            redirect_hit;
  logic            load_use;
  logic [1:0]      fwd_a_raw;
  logic [1:0]      fwd_b_raw;

  fwd_unit u_fwd (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  assign fwd_a = reset ? FWD_REG : fwd_a_raw;
  assign fwd_b = reset ? FWD_REG : fwd_b_raw;

  // The cycle dmem_ready rises is an ordinary cycle, so freeze always needs !dmem_ready.
  assign halted       = (state == HALT);
  assign freeze       = !halted && (state == MEM_WAIT || dmem_req) && !dmem_ready;
  assign redirect_hit = !halted && !freeze && ex_redirect;
  assign load_use     = !halted && !freeze && !ex_redirect && ex_mem_read && ex_rd != 5'd0 &&
                        ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  assign timeout_err = halted;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (halted || freeze) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (redirect_hit) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready)
            state <= RUN;
          else if (wait_cnt == WC_LAST)
            state <= HALT;
          else
            wait_cnt <= wait_cnt + WC_W'(1);
        end
        default: state <= HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_hit && flush_events != {CNT_W{1'b1}})
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
// Directed literal checks followed by randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TB_TO = 4;
  localparam int TB_CW = 4;
  localparam longint CNT_MAX = (longint'(1) << TB_CW) - 1;

  typedef struct packed {
    logic pc, ifid, idex, exmem, f_ifid, f_idex, f_memwb, terr;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush, memwb_flush, timeout_err;
  logic [1:0] fwd_a, fwd_b;
  logic [TB_CW-1:0] stall_cycles, flush_events;
  ctrl_t dut_ctrl;

  int n_chk  = 0;
  int n_fail = 0;

  bit     m_halt, m_wait;
  int     m_waited;
  longint m_stalls, m_flushes;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TB_TO), .CNT_W(TB_CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign dut_ctrl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                     ifid_flush, idex_flush, memwb_flush, timeout_err};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (reset) return 2'd0;
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'd1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic ctrl_t m_ctrl();
    bit hazard;
    hazard = ex_mem_read && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (reset)                                        return 8'b0000_1110;
    if (m_halt)                                       return 8'b1111_0011;
    if ((m_wait || dmem_req) && !dmem_ready)          return 8'b1111_0010;
    if (ex_redirect)                                  return 8'b0000_1100;
    if (hazard)                                       return 8'b1100_0100;
    return 8'b0000_0000;
  endfunction

  function automatic longint sat(input longint n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // Reference model: counts wait cycles directly and halts once TB_TO of them pass unserved.
  always @(posedge clk or posedge reset) begin
    ctrl_t c;
    if (reset) begin
      m_halt = 0; m_wait = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      c = m_ctrl();
      if (c.pc) m_stalls++;
      if (c.f_ifid) m_flushes++;
      if (!m_halt) begin
        if (m_wait) begin
          if (dmem_ready) m_wait = 0;
          else begin
            m_waited++;
            if (m_waited == TB_TO) begin m_halt = 1; m_wait = 0; end
          end
        end else if (dmem_req && !dmem_ready) begin
          m_wait = 1; m_waited = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ctrl", 32'(dut_ctrl), 32'(m_ctrl()));
    chk("fwd_a", 32'(fwd_a), 32'(m_fwd(ex_rs1)));
    chk("fwd_b", 32'(fwd_b), 32'(m_fwd(ex_rs2)));
    chk("stall_cycles", 32'(stall_cycles), 32'(sat(m_stalls)));
    chk("flush_events", 32'(flush_events), 32'(sat(m_flushes)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect} = '0;
    {mem_reg_write, wb_reg_write, dmem_req, dmem_ready} = '0;
  endtask

  initial begin
    bit slow = 0;
    clr();
    reset = 1'b1;
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
    #2;
    chk("rst_pc_stall", 32'(pc_stall), 0);
    chk("rst_ifid_flush", 32'(ifid_flush), 1);
    chk("rst_memwb_flush", 32'(memwb_flush), 1);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    step(); step();
    reset = 1'b0;
    wb_rd = 5; wb_reg_write = 1;
    #1 chk("fwd_exmem", 32'(fwd_a), 1);
    mem_reg_write = 0;
    #1 chk("fwd_memwb", 32'(fwd_a), 2);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0;
    #1 chk("fwd_x0", 32'(fwd_a), 0);
    ex_rs2 = 7; wb_rd = 7;
    #1 chk("fwd_b_memwb", 32'(fwd_b), 2);

    step(); clr();
    ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1;
    #1 chk("lu_pc_stall", 32'(pc_stall), 1);
    chk("lu_ifid_stall", 32'(ifid_stall), 1);
    chk("lu_idex_flush", 32'(idex_flush), 1);
    chk("lu_idex_stall", 32'(idex_stall), 0);
    step(); ex_mem_read = 0;
    #1 chk("lu_count", 32'(stall_cycles), 1);
    chk("lu_one_cycle", 32'(pc_stall), 0);
    ex_mem_read = 1; id_use_rs2 = 0;
    #1 chk("lu_unused_rs2", 32'(pc_stall), 0);
    id_use_rs2 = 1; ex_redirect = 1;
    #1 chk("redir_ifid_flush", 32'(ifid_flush), 1);
    chk("redir_idex_flush", 32'(idex_flush), 1);
    chk("redir_over_lu", 32'(pc_stall), 0);
    step(); clr();
    #1 chk("redir_count", 32'(flush_events), 1);

    ex_redirect = 1; dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("freeze_pc_stall", 32'(pc_stall), 1);
      chk("freeze_memwb_flush", 32'(memwb_flush), 1);
      chk("freeze_no_redirect", 32'(ifid_flush), 0);
      step();
    end
    dmem_ready = 1;
    #1 chk("ready_no_stall", 32'(pc_stall), 0);
    chk("ready_redirect", 32'(ifid_flush), 1);
    chk("ready_memwb", 32'(memwb_flush), 0);
    step(); clr();
    #1 chk("wait_flush_count", 32'(flush_events), 2);
    chk("wait_stall_count", 32'(stall_cycles), 4);
    chk("back_to_run", 32'(pc_stall), 0);

    dmem_req = 1; dmem_ready = 0;
    repeat (4) step();
    chk("pre_timeout", 32'(timeout_err), 0);
    step();
    chk("timeout", 32'(timeout_err), 1);
    dmem_ready = 1;
    #1 chk("halt_sticky", 32'(timeout_err), 1);
    chk("halt_pc_stall", 32'(pc_stall), 1);
    chk("halt_memwb", 32'(memwb_flush), 1);
    repeat (20) step();
    chk("stall_saturate", 32'(stall_cycles), 15);
    #2 reset = 1;
    #1 chk("areset_terr", 32'(timeout_err), 0);
    chk("areset_stalls", 32'(stall_cycles), 0);
    chk("areset_flushes", 32'(flush_events), 0);
    step(); reset = 0; clr();
    #1 chk("areset_run", 32'(pc_stall), 0);

    for (int i = 0; i < 3000; i++) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) slow = !slow;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_mem_read = 1'($urandom); ex_redirect = ($urandom_range(0, 3) == 0);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 9) < (slow ? 1 : 6));
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
